// File: rtl/carry_skip_subtractor_seq.sv
// Sequential 32-bit subtractor: one GROUP_W-bit group per clock, carry-lookahead
// inside each group and a skip bypass when the whole group propagates.
module carry_skip_subtractor_seq #(
    parameter int GROUP_W = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_diff,
    output logic        o_borrow,
    output logic        o_overflow,
    output logic        o_zero
);

    localparam int N = 32 / GROUP_W;
    localparam logic [5:0] LAST = 6'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] nb_q, nb_d;
    logic        a31_q, a31_d;
    logic        b31_q, b31_d;
    logic        carry_q, carry_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] diff_q, diff_d;
    logic        borrow_q, borrow_d;
    logic        overflow_q, overflow_d;
    logic        zero_q, zero_d;
    logic [4:0]  base_s;
    logic [GROUP_W:0] grp_s;

    // Returns {carry_out, sum}; carry_out takes the skip path when every bit propagates.
    function automatic logic [GROUP_W:0] group_add(
        input logic [GROUP_W-1:0] a,
        input logic [GROUP_W-1:0] nb,
        input logic               cin
    );
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] s;
        logic [GROUP_W:0]   c;
        p    = a ^ nb;
        g    = a & nb;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < GROUP_W; k++) begin
            c[k+1] = g[k] | (p[k] & c[k]);
            s[k]   = p[k] ^ c[k];
        end
        return {((&p) ? cin : c[GROUP_W]), s};
    endfunction

    // Next-state, datapath and flag computation.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        nb_d       = nb_q;
        a31_d      = a31_q;
        b31_d      = b31_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        base_s     = 5'(int'(cnt_q) * GROUP_W);
        grp_s      = group_add(a_q[base_s +: GROUP_W], nb_q[base_s +: GROUP_W], carry_q);
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d        = i_a;
                    nb_d       = ~i_b;
                    a31_d      = i_a[31];
                    b31_d      = i_b[31];
                    carry_d    = 1'b1;
                    cnt_d      = 6'd0;
                    diff_d     = 32'd0;
                    borrow_d   = 1'b0;
                    overflow_d = 1'b0;
                    zero_d     = 1'b0;
                    state_d    = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d[base_s +: GROUP_W] = grp_s[GROUP_W-1:0];
                carry_d = grp_s[GROUP_W];
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    borrow_d   = ~grp_s[GROUP_W];
                    overflow_d = (a31_q != b31_q) & (diff_d[31] != a31_q);
                    zero_d     = (diff_d == 32'd0);
                    state_d    = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            a_q        <= 32'd0;
            nb_q       <= 32'd0;
            a31_q      <= 1'b0;
            b31_q      <= 1'b0;
            carry_q    <= 1'b0;
            cnt_q      <= 6'd0;
            diff_q     <= 32'd0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            nb_q       <= nb_d;
            a31_q      <= a31_d;
            b31_q      <= b31_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = (state_q == DONE);
    assign o_diff     = diff_q;
    assign o_borrow   = borrow_q;
    assign o_overflow = overflow_q;
    assign o_zero     = zero_q;

endmodule
